// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3
// encodings, FSM states, RISC-V special-case result constants.
package mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } mdu_state_e;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation: absolute value on the operand side,
// sign restoration on the result side.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 RV32M multiply/divide unit, fixed XLEN+2 cycle latency.
// Optional macro MDU_EARLY_OUT_EN: trivial/special cases bypass the CALC loop.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [2:0]      OP,
    input  logic [XLEN-1:0] SRC_A,
    input  logic [XLEN-1:0] SRC_B,
    input  logic [AW-1:0]   RD_ADDR,
    output logic            BUSY,
    output logic            WB_WE,
    output logic [AW-1:0]   WB_ADDR,
    output logic [XLEN-1:0] WB_DATA
);

    localparam int CW = $clog2(XLEN);

    mdu_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic                neg_q, neg_d;
    logic                spec_q, spec_d;
    logic [XLEN-1:0]     spec_val_q, spec_val_d;
    logic [XLEN-1:0]     opd_q, opd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                busy_q, busy_d;
    logic                we_q, we_d;
    logic [AW-1:0]       wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;

    // Operand conditioning
    logic            a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div0, ovf, mul_zero, special;
    logic [XLEN-1:0] special_val;

    assign a_neg = op_a_signed(OP) & SRC_A[XLEN-1];
    assign b_neg = op_b_signed(OP) & SRC_B[XLEN-1];

    mdu_sign_fix #(.W(XLEN)) u_abs_a (.val_i(SRC_A), .neg_i(a_neg), .val_o(abs_a));
    mdu_sign_fix #(.W(XLEN)) u_abs_b (.val_i(SRC_B), .neg_i(b_neg), .val_o(abs_b));

    assign div0     = op_is_div(OP) && (SRC_B == '0);
    assign ovf      = ((OP == OP_DIV) || (OP == OP_REM)) && (SRC_A == INT_MIN) && (SRC_B == '1);
    assign mul_zero = !op_is_div(OP) && ((SRC_A == '0) || (SRC_B == '0));
    assign special  = div0 || ovf || mul_zero;

    // OP[1] separates REM/REMU from DIV/DIVU within the divide group
    always_comb begin
        special_val = '0;
        if (div0)
            special_val = OP[1] ? SRC_A : DIV0_Q;
        else if (ovf)
            special_val = OP[1] ? '0 : INT_MIN;
    end

    // Multiply step: conditional add into the high half, then shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide step: partial remainder needs XLEN+1 bits before the compare
    logic [XLEN:0]     div_rem;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    assign div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = {1'b0, div_rem} - {2'b00, opd_q};
    assign div_ge   = !div_diff[XLEN+1];
    assign div_next = {(div_ge ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0]),
                       acc_q[XLEN-2:0], div_ge};

    // Result side
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic [XLEN-1:0]   result;

    assign fix_in = op_is_div(op_q)
                  ? {{XLEN{1'b0}}, (op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0])}
                  : acc_q;

    mdu_sign_fix #(.W(2*XLEN)) u_res (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));

    always_comb begin
        result = fix_out[2*XLEN-1:XLEN];
        if (spec_q)
            result = spec_val_q;
        else if (op_is_div(op_q) || (op_q == OP_MUL))
            result = fix_out[XLEN-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            opd_q      <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            opd_q      <= opd_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rd_d       = rd_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        opd_d      = opd_q;
        acc_d      = acc_q;
        we_d       = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            ST_IDLE: begin
                if (START && !FLUSH) begin
                    op_d       = OP;
                    rd_d       = RD_ADDR;
                    neg_d      = (op_is_div(OP) && OP[1]) ? a_neg : (a_neg ^ b_neg);
                    spec_d     = special;
                    spec_val_d = special_val;
                    opd_d      = op_is_div(OP) ? abs_b : abs_a;
                    acc_d      = {{XLEN{1'b0}}, (op_is_div(OP) ? abs_a : abs_b)};
                    cnt_d      = CW'(XLEN - 1);
                    state_d    = ST_CALC;
`ifdef MDU_EARLY_OUT_EN
                    if (special)
                        state_d = ST_FIN;
`else
                    state_d = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = op_is_div(op_q) ? div_next : mul_next;
                    if (cnt_q == '0)
                        state_d = ST_FIN;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                if (!FLUSH) begin
                    wb_data_d = result;
                    wb_addr_d = rd_q;
                    we_d      = (rd_q != '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d  = (state_d != ST_IDLE);

    assign BUSY    = busy_q;
    assign WB_WE   = we_q;
    assign WB_ADDR = wb_addr_q;
    assign WB_DATA = wb_data_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized scoreboard bench for mdu_iter against an arithmetic RV32M model.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int LAT = 34;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        FLUSH;
  logic [2:0]  OP;
  logic [31:0] SRC_A;
  logic [31:0] SRC_B;
  logic [4:0]  RD_ADDR;
  logic        BUSY;
  logic        WB_WE;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;

  mdu_iter #(.XLEN(32), .AW(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .FLUSH(FLUSH), .OP(OP),
    .SRC_A(SRC_A), .SRC_B(SRC_B), .RD_ADDR(RD_ADDR),
    .BUSY(BUSY), .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] cyc = '0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (WB_WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wb: got addr=%0d data=%h expected no write-back (cycle %0d)",
                 WB_ADDR, WB_DATA, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_addr", 64'(WB_ADDR), 64'(mon_e.addr));
        check("wb_data", 64'(WB_DATA), 64'(mon_e.data));
        check("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, za, sb, zb, p;
    int qa, qb;
    bit ovf;
    sa  = {{32{a[31]}}, a};
    za  = {32'b0, a};
    sb  = {{32{b[31]}}, b};
    zb  = {32'b0, b};
    qa  = a;
    qb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * zb; return p[63:32]; end
      OP_MULHU:  begin p = za * zb; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(qa / qb);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(qa % qb);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sp;
    if (op[2])
      sp = (b == 0) || (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    else
      sp = (a == 0) || (b == 0);
`ifdef MDU_EARLY_OUT_EN
    return sp ? 2 : LAT;
`else
    return sp ? LAT : LAT;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a posedge; returns #1 after the write-back edge, so a
  // following call issues START in the WB_WE cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit junk, input int flush_k);
    int   lat;
    exp_t e;
    lat     = lat_of(op, a, b);
    OP      = op;
    SRC_A   = a;
    SRC_B   = b;
    RD_ADDR = rd;
    START   = 1'b1;
    if (rd != 0 && flush_k <= 0) begin
      e.addr = rd;
      e.data = ref_mdu(op, a, b);
      e.cyc  = cyc + 32'(lat);
      exp_q.push_back(e);
    end
    for (int k = 1; k <= lat; k++) begin
      @(posedge CLK);
      #1;
      START = 1'b0;
      FLUSH = 1'b0;
      if (flush_k > 0 && k == flush_k + 1) begin
        check("busy_after_flush", 64'(BUSY), 64'd0);
        break;
      end
      if (k == flush_k) FLUSH = 1'b1;
      if (k == 1) check("busy_running", 64'(BUSY), 64'd1);
      if (k == lat - 1 && lat > 2) check("busy_last", 64'(BUSY), 64'd1);
      if (k == lat) check("busy_done", 64'(BUSY), 64'd0);
      if (junk && k < lat) begin
        START   = 1'($urandom_range(0, 1));
        OP      = 3'($urandom);
        SRC_A   = $urandom;
        SRC_B   = $urandom;
        RD_ADDR = 5'($urandom);
      end
    end
    START = 1'b0;
    FLUSH = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST_N   = 1'b0;
    START   = 1'b0;
    FLUSH   = 1'b0;
    OP      = '0;
    SRC_A   = '0;
    SRC_B   = '0;
    RD_ADDR = '0;
    #12;
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_wb_we", 64'(WB_WE), 64'd0);
    check("reset_wb_addr", 64'(WB_ADDR), 64'd0);
    check("reset_wb_data", 64'(WB_DATA), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // directed, issued back-to-back
    run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  1'b0, 0);
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  1'b1, 0);
    run_op(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  1'b0, 0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  1'b1, 0);
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  1'b0, 0);
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 1'b1, 0);
    run_op(OP_DIVU,   32'd5,          32'd0,         5'd11, 1'b1, 0);
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 1'b0, 0);
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 1'b1, 0);
    run_op(OP_DIV,    32'hFFFF_FFFB,  32'd0,         5'd14, 1'b0, 0);
    run_op(OP_REMU,   32'h1234_5678,  32'd0,         5'd15, 1'b0, 0);
    run_op(OP_MUL,    32'd0,          32'h1234_5678, 5'd16, 1'b0, 0);
    run_op(OP_DIVU,   32'hFFFF_FFFF,  32'd3,         5'd0,  1'b0, 0);
    run_op(OP_DIVU,   32'hFFFF_FFFF,  32'h8000_0001, 5'd17, 1'b0, 0);

    // randomized
    for (int i = 0; i < 60; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(3'($urandom), pick_operand(), pick_operand(), rd, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end

    // flush in CALC and in FIN: write-back registers must hold
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd20, 1'b0, 10);
    repeat (40) @(posedge CLK);
    #1;
    check("hold_data_calc_flush", 64'(WB_DATA), 64'hFFFF_FFEB);
    check("hold_addr_calc_flush", 64'(WB_ADDR), 64'd5);
    run_op(OP_MULHU, 32'h1357_9BDF, 32'h2468_ACE0, 5'd21, 1'b0, LAT - 1);
    repeat (40) @(posedge CLK);
    #1;
    check("hold_data_fin_flush", 64'(WB_DATA), 64'hFFFF_FFEB);
    check("hold_addr_fin_flush", 64'(WB_ADDR), 64'd5);

    // FLUSH and START together in IDLE
    OP = OP_MUL; SRC_A = 32'd3; SRC_B = 32'd4; RD_ADDR = 5'd22;
    START = 1'b1;
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    FLUSH = 1'b0;
    check("flush_start_idle_busy", 64'(BUSY), 64'd0);
    repeat (40) @(posedge CLK);
    #1;

    // asynchronous reset mid-operation
    OP = OP_DIV; SRC_A = 32'd1000; SRC_B = 32'd7; RD_ADDR = 5'd23;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (14) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check("midop_reset_busy", 64'(BUSY), 64'd0);
    check("midop_reset_wb_we", 64'(WB_WE), 64'd0);
    check("midop_reset_wb_addr", 64'(WB_ADDR), 64'd0);
    check("midop_reset_wb_data", 64'(WB_DATA), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) @(posedge CLK);
    #1;

    run_op(OP_REMU, 32'd1000, 32'd7, 5'd24, 1'b0, 0);
    repeat (5) @(posedge CLK);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
